// File: rtl/aes_round_key_reader.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_key_reader
// Brief    : Stores the 15 AES-256 round keys written by a key schedule and
//            replays them, one per cycle, in forward (encrypt) or reverse
//            (decrypt) order with registered outputs and latency 1.
// Option   : AES_RKR_INV_MIX_EN - decrypt-mode keys for rounds 1..13 are
//            passed through InvMixColumns (equivalent inverse cipher).
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_key_reader (
   input  logic         inClk,
   input  logic         inRst,
   input  logic         inKeyWr,
   input  logic [127:0] inKey,
   input  logic         inStart,
   input  logic         inDecrypt,
   output logic         outKeyReady,
   output logic [127:0] outRoundKey,
   output logic [3:0]   outRoundIdx,
   output logic         outRoundValid,
   output logic         outLastRound,
   output logic         outBusy,
   output logic         outKeyErr
);

   localparam int unsigned NUM_KEYS = 15;
   localparam logic [3:0]  LAST_IDX = 4'd14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [3:0]   cnt_q, cnt_d;
   logic         dec_q, dec_d;
   logic [3:0]   wp_q, wp_d;
   logic         ready_q, ready_d;
   logic         err_q, err_d;
   logic         valid_q, valid_d;
   logic         last_q, last_d;
   logic [3:0]   idx_q, idx_d;
   logic [127:0] key_q, key_d;

   logic [127:0] key_mem [NUM_KEYS];
   logic         emit;
   logic         wr_en;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;
   logic [127:0] out_key;

   // Sequencer: accept a start only from IDLE with a complete key set,
   // then step the round counter once per RUN cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dec_d   = dec_q;
      emit    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (inStart && ready_q) begin
               state_d = ST_RUN;
               cnt_d   = '0;
               dec_d   = inDecrypt;
               emit    = 1'b1;
            end
         end
         ST_RUN: begin
            if (cnt_q == LAST_IDX) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
               emit  = 1'b1;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Reverse order in decrypt mode; the buffer is read before any write on
   // the same edge lands, so a simultaneous start sees the old contents.
   assign rd_idx = dec_d ? (LAST_IDX - cnt_d) : cnt_d;
   assign rd_key = key_mem[rd_idx];

`ifdef AES_RKR_INV_MIX_EN
   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] m2 [4];
      logic [7:0] m4 [4];
      logic [7:0] m8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         m2[i] = xt(a[i]);
         m4[i] = xt(m2[i]);
         m8[i] = xt(m4[i]);
         m9[i] = m8[i] ^ a[i];
         mb[i] = m8[i] ^ m2[i] ^ a[i];
         md[i] = m8[i] ^ m4[i] ^ a[i];
         me[i] = m8[i] ^ m4[i] ^ m2[i];
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   logic [127:0] inv_key;
   logic         inv_sel;

   for (genvar c = 0; c < 4; c++) begin : g_inv_col
      assign inv_key[127-32*c -: 32] = inv_mix_col(rd_key[127-32*c -: 32]);
   end

   // First and last round keys are used raw by the equivalent inverse cipher.
   assign inv_sel = dec_d && (rd_idx != 4'd0) && (rd_idx != LAST_IDX);
   assign out_key = inv_sel ? inv_key : rd_key;
`else
   assign out_key = rd_key;
`endif

   // Output register next values: key holds while idle, index reads zero.
   always_comb begin
      valid_d = emit;
      last_d  = emit && (cnt_d == LAST_IDX);
      idx_d   = emit ? rd_idx : 4'd0;
      key_d   = emit ? out_key : key_q;
   end

   // Key write path: writes are dropped (and flagged) whenever a sequence
   // is in progress so the replayed keys never change mid-block.
   always_comb begin
      wp_d    = wp_q;
      ready_d = ready_q;
      err_d   = err_q;
      wr_en   = 1'b0;
      if (inKeyWr) begin
         if (state_q != ST_IDLE) begin
            err_d = 1'b1;
         end else begin
            wr_en = 1'b1;
            wp_d  = (wp_q == LAST_IDX) ? 4'd0 : wp_q + 4'd1;
            if (wp_q == 4'd0) begin
               ready_d = 1'b0;
            end else if (wp_q == LAST_IDX) begin
               ready_d = 1'b1;
            end
         end
      end
   end

   // Round-key buffer; deliberately not reset, outKeyReady guards stale data.
   always_ff @(posedge inClk) begin
      if (wr_en) begin
         key_mem[wp_q] <= inKey;
      end
   end

   // Control and output registers with asynchronous reset.
   always_ff @(posedge inClk or posedge inRst) begin
      if (inRst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         dec_q   <= 1'b0;
         wp_q    <= '0;
         ready_q <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         idx_q   <= '0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dec_q   <= dec_d;
         wp_q    <= wp_d;
         ready_q <= ready_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         idx_q   <= idx_d;
         key_q   <= key_d;
      end
   end

   assign outKeyReady   = ready_q;
   assign outRoundKey   = key_q;
   assign outRoundIdx   = idx_q;
   assign outRoundValid = valid_q;
   assign outLastRound  = last_q;
   assign outBusy       = (state_q != ST_IDLE);
   assign outKeyErr     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_key_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_round_key_reader
// Brief    : Directed, table-driven bench for aes_round_key_reader using the
//            AES-256 schedule of key 000102..1f.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_round_key_reader;

   logic         inClk;
   logic         inRst;
   logic         inKeyWr;
   logic [127:0] inKey;
   logic         inStart;
   logic         inDecrypt;
   logic         outKeyReady;
   logic [127:0] outRoundKey;
   logic [3:0]   outRoundIdx;
   logic         outRoundValid;
   logic         outLastRound;
   logic         outBusy;
   logic         outKeyErr;

   int total = 0;
   int bad   = 0;

   aes_round_key_reader dut (
      .inClk         (inClk),
      .inRst         (inRst),
      .inKeyWr       (inKeyWr),
      .inKey         (inKey),
      .inStart       (inStart),
      .inDecrypt     (inDecrypt),
      .outKeyReady   (outKeyReady),
      .outRoundKey   (outRoundKey),
      .outRoundIdx   (outRoundIdx),
      .outRoundValid (outRoundValid),
      .outLastRound  (outLastRound),
      .outBusy       (outBusy),
      .outKeyErr     (outKeyErr)
   );

   initial inClk = 1'b0;
   always #5 inClk = ~inClk;

   typedef struct {
      logic         wr;
      logic [127:0] key;
      logic         start;
      logic         dec;
      logic         e_valid;
      logic [3:0]   e_idx;
      logic [127:0] e_key;
      logic         e_last;
      logic         e_busy;
      logic         e_ready;
      logic         e_err;
   } vec_t;

   logic [127:0] sched [15];
   vec_t         tbl [$];

   localparam logic [127:0] KX   = 128'hdeadbeef_cafef00d_01234567_89abcdef;
   localparam logic [127:0] JUNK = 128'hffffffff_ffffffff_ffffffff_ffffffff;

`ifdef AES_RKR_INV_MIX_EN
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] k);
      logic [7:0]   coef [4];
      logic [127:0] r;
      logic [7:0]   acc;
      coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(coef[(j - row + 4) % 4], k[127-32*c-8*j -: 8]);
            r[127-32*c-8*row -: 8] = acc;
         end
      end
      return r;
   endfunction
`endif

   function automatic logic [127:0] exp_key(input int idx, input logic dec);
`ifdef AES_RKR_INV_MIX_EN
      if (dec && idx >= 1 && idx <= 13) return inv_mix(sched[idx]);
`endif
      return (dec === 1'b0 || dec === 1'b1) ? sched[idx] : 128'h0;
   endfunction

   task automatic tick();
      @(posedge inClk);
      #1;
   endtask

   task automatic drive(input logic wr, input logic [127:0] key,
                        input logic start, input logic dec);
      inKeyWr   = wr;
      inKey     = key;
      inStart   = start;
      inDecrypt = dec;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input logic ev, input logic [3:0] ei,
                             input logic [127:0] ek, input logic el, input logic eb,
                             input logic er, input logic ee);
      chk({tag, ".valid"}, {127'b0, outRoundValid}, {127'b0, ev});
      chk({tag, ".idx"},   {124'b0, outRoundIdx},   {124'b0, ei});
      chk({tag, ".key"},   outRoundKey,             ek);
      chk({tag, ".last"},  {127'b0, outLastRound},  {127'b0, el});
      chk({tag, ".busy"},  {127'b0, outBusy},       {127'b0, eb});
      chk({tag, ".ready"}, {127'b0, outKeyReady},   {127'b0, er});
      chk({tag, ".err"},   {127'b0, outKeyErr},     {127'b0, ee});
   endtask

   task automatic add_row(input logic wr, input logic [127:0] key, input logic start,
                          input logic dec, input logic ev, input logic [3:0] ei,
                          input logic [127:0] ek, input logic el, input logic eb,
                          input logic er, input logic ee);
      vec_t v;
      v.wr = wr; v.key = key; v.start = start; v.dec = dec;
      v.e_valid = ev; v.e_idx = ei; v.e_key = ek; v.e_last = el;
      v.e_busy = eb; v.e_ready = er; v.e_err = ee;
      tbl.push_back(v);
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      sched[0]  = 128'h000102030405060708090a0b0c0d0e0f;
      sched[1]  = 128'h101112131415161718191a1b1c1d1e1f;
      sched[2]  = 128'ha573c29fa176c498a97fce93a572c09c;
      sched[3]  = 128'h1651a8cd0244beda1a5da4c10640bade;
      sched[4]  = 128'hae87dff00ff11b68a68ed5fb03fc1567;
      sched[5]  = 128'h6de1f1486fa54f9275f8eb5373b8518d;
      sched[6]  = 128'hc656827fc9a799176f294cec6cd5598b;
      sched[7]  = 128'h3de23a75524775e727bf9eb45407cf39;
      sched[8]  = 128'h0bdc905fc27b0948ad5245a4c1871c2f;
      sched[9]  = 128'h45f5a66017b2d387300d4d33640a820a;
      sched[10] = 128'h7ccff71cbeb4fe5413e6bbf0d261a7df;
      sched[11] = 128'hf01afafee7a82979d7a5644ab3afe640;
      sched[12] = 128'h2541fe719bf500258813bbd55a721c0a;
      sched[13] = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
      sched[14] = 128'h24fc79ccbf0979e9371ac23c6d68de36;

      // Rows: inputs are applied before an edge, outputs checked after it.
      for (int i = 0; i < 15; i++)
         add_row(1'b1, sched[i], 1'b0, 1'b0, 1'b0, 4'd0, 128'h0, 1'b0, 1'b0, (i == 14), 1'b0);
      // Encrypt run; extra starts during RUN (k=7) and DONE must be ignored.
      add_row(1'b0, 128'h0, 1'b1, 1'b0, 1'b1, 4'd0, sched[0], 1'b0, 1'b1, 1'b1, 1'b0);
      for (int k = 1; k < 15; k++)
         add_row(1'b0, 128'h0, (k == 7), 1'b1, 1'b1, 4'(k), sched[k], (k == 14), 1'b1, 1'b1, 1'b0);
      add_row(1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 4'd0, sched[14], 1'b0, 1'b1, 1'b1, 1'b0);
      add_row(1'b0, 128'h0, 1'b1, 1'b0, 1'b0, 4'd0, sched[14], 1'b0, 1'b0, 1'b1, 1'b0);
      // Decrypt run.
      add_row(1'b0, 128'h0, 1'b1, 1'b1, 1'b1, 4'd14, exp_key(14, 1'b1), 1'b0, 1'b1, 1'b1, 1'b0);
      for (int k = 1; k < 15; k++)
         add_row(1'b0, 128'h0, 1'b0, 1'b0, 1'b1, 4'(14 - k), exp_key(14 - k, 1'b1), (k == 14),
                 1'b1, 1'b1, 1'b0);
      add_row(1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 4'd0, exp_key(0, 1'b1), 1'b0, 1'b1, 1'b1, 1'b0);
      add_row(1'b0, 128'h0, 1'b0, 1'b0, 1'b0, 4'd0, exp_key(0, 1'b1), 1'b0, 1'b0, 1'b1, 1'b0);

      // Reset state.
      drive(1'b0, 128'h0, 1'b0, 1'b0);
      inRst = 1'b0;
      #1 inRst = 1'b1;
      tick();
      check_outs("reset", 1'b0, 4'd0, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge inClk);
      #1 inRst = 1'b0;

      foreach (tbl[r]) begin
         drive(tbl[r].wr, tbl[r].key, tbl[r].start, tbl[r].dec);
         tick();
         check_outs($sformatf("row%0d", r), tbl[r].e_valid, tbl[r].e_idx, tbl[r].e_key,
                    tbl[r].e_last, tbl[r].e_busy, tbl[r].e_ready, tbl[r].e_err);
      end
      drive(1'b0, 128'h0, 1'b0, 1'b0);

      // Write during a decrypt run: dropped, error flagged, keys untouched.
      drive(1'b0, 128'h0, 1'b1, 1'b1);
      tick();
      chk("wrbusy.idx0", {124'b0, outRoundIdx}, 128'd14);
      for (int k = 1; k < 15; k++) begin
         drive((k == 2), JUNK, 1'b0, 1'b0);
         tick();
         chk($sformatf("wrbusy.key%0d", k), outRoundKey, exp_key(14 - k, 1'b1));
         chk($sformatf("wrbusy.err%0d", k), {127'b0, outKeyErr}, {127'b0, (k >= 2)});
      end
      drive(1'b0, 128'h0, 1'b0, 1'b0);
      tick();
      tick();
      chk("wrbusy.busy_end", {127'b0, outBusy}, 128'd0);

      // wp must still be 0: this write clears ready.
      drive(1'b1, sched[0], 1'b0, 1'b0);
      tick();
      chk("wp0.ready_cleared", {127'b0, outKeyReady}, 128'd0);
      // Start with no ready key set is ignored.
      drive(1'b0, 128'h0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("noready.valid%0d", k), {127'b0, outRoundValid}, 128'd0);
         chk($sformatf("noready.busy%0d", k), {127'b0, outBusy}, 128'd0);
      end
      for (int i = 1; i < 15; i++) begin
         drive(1'b1, sched[i], 1'b0, 1'b0);
         tick();
      end
      chk("refill.ready", {127'b0, outKeyReady}, 128'd1);
      chk("refill.err_sticky", {127'b0, outKeyErr}, 128'd1);

      // Start and write on the same edge: start sees the old entry 0.
      drive(1'b1, KX, 1'b1, 1'b0);
      tick();
      drive(1'b0, 128'h0, 1'b0, 1'b0);
      chk("samedge.key0", outRoundKey, sched[0]);
      chk("samedge.ready", {127'b0, outKeyReady}, 128'd0);
      for (int k = 0; k < 16; k++) tick();
      chk("samedge.idle", {127'b0, outBusy}, 128'd0);
      for (int i = 1; i < 15; i++) begin
         drive(1'b1, sched[i], 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 128'h0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 128'h0, 1'b0, 1'b0);
      chk("samedge.newkey0", outRoundKey, KX);
      tick();
      chk("samedge.key1", outRoundKey, sched[1]);
      for (int k = 0; k < 15; k++) tick();

      // Asynchronous reset in the middle of a run.
      drive(1'b0, 128'h0, 1'b1, 1'b0);
      tick();
      drive(1'b0, 128'h0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) tick();
      chk("midrst.idx5", {124'b0, outRoundIdx}, 128'd5);
      chk("midrst.key5", outRoundKey, sched[5]);
      #2 inRst = 1'b1;
      #1;
      check_outs("midrst.async", 1'b0, 4'd0, 128'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      inRst = 1'b0;
      drive(1'b0, 128'h0, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("postrst.valid%0d", k), {127'b0, outRoundValid}, 128'd0);
         chk($sformatf("postrst.busy%0d", k), {127'b0, outBusy}, 128'd0);
      end
      drive(1'b0, 128'h0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_round_key_reader.md
AES_ROUND_KEY_READER -- requirements
Module: aes_round_key_reader

Interface
REQ-001 The block SHALL have these ports, one clock domain:
- inClk  in  1  clock, all state updates on rising edge
- inRst  in  1  asynchronous, active-high reset
- inKeyWr  in  1  round-key write strobe from key schedule, one per cycle
- inKey  in  128  round key accompanying inKeyWr
- inStart  in  1  request to sequence one block's round keys
- inDecrypt  in  1  direction, sampled with accepted inStart (1 = reverse order)
- outKeyReady  out  1  all 15 round keys of the current key stored
- outRoundKey  out  128  round key for the current round
- outRoundIdx  out  4  logical round number 0..14 of outRoundKey
- outRoundValid  out  1  outRoundKey/outRoundIdx valid this cycle
- outLastRound  out  1  high with the final round key of a sequence
- outBusy  out  1  sequence in progress
- outKeyErr  out  1  sticky: key write dropped while busy

Function
REQ-002 The block SHALL contain a 15 x 128-bit round-key buffer and a 4-bit write pointer wp.
REQ-003 On inKeyWr with outBusy low, the block SHALL store inKey at entry wp; wp SHALL increment, wrapping 14 -> 0.
REQ-004 A write at wp = 0 SHALL clear outKeyReady in the same edge; a write at wp = 14 SHALL set outKeyReady.
REQ-005 inKeyWr while outBusy is high SHALL be dropped, SHALL leave wp and buffer unchanged, and SHALL set outKeyErr.
REQ-006 The FSM SHALL have states IDLE, RUN, DONE; reset state IDLE.
REQ-007 IDLE -> RUN SHALL occur when inStart = 1 and outKeyReady = 1; inStart is ignored otherwise, including while in RUN or DONE.
REQ-008 RUN SHALL last exactly 15 cycles; outRoundValid SHALL be high in every RUN cycle and low otherwise.
REQ-009 Encrypt: RUN cycle k (k = 0..14) SHALL present buffer entry k with outRoundIdx = k.
REQ-010 Decrypt: RUN cycle k SHALL present buffer entry 14-k with outRoundIdx = 14-k.
REQ-011 Outputs SHALL be registered; the first valid round key SHALL appear the cycle after the inStart acceptance edge (latency 1).
REQ-012 outLastRound SHALL be high only in RUN cycle 14.
REQ-013 RUN -> DONE after cycle 14; DONE SHALL last one cycle and then go to IDLE; outBusy SHALL be high in RUN and DONE.
REQ-014 inKeyWr and inStart arriving on the same edge in IDLE: the start SHALL use the buffer content before that write, and the write SHALL be performed.
REQ-015 When outRoundValid is low, outRoundKey SHALL hold its last value and outRoundIdx SHALL read 0.

Reset
REQ-016 inRst high SHALL immediately force: state IDLE, wp = 0, outKeyReady = 0, outRoundValid = 0, outLastRound = 0, outBusy = 0, outKeyErr = 0, outRoundIdx = 0, outRoundKey = 0.
REQ-017 Buffer contents need not be cleared; outKeyReady = 0 SHALL block use of stale keys.
REQ-018 Reset asserted mid-RUN SHALL abort the sequence with no further outRoundValid.

Configuration
REQ-019 Macro AES_RKR_INV_MIX_EN SHALL select equivalent-inverse-cipher key output.
REQ-020 With AES_RKR_INV_MIX_EN defined, in decrypt mode, round keys with outRoundIdx 1..13 SHALL be output after InvMixColumns applied per 32-bit column. Indices 0 and 14, and all encrypt-mode keys, SHALL be output unmodified. Latency SHALL stay 1.
REQ-021 Without the macro, all round keys SHALL be output unmodified and no InvMixColumns logic SHALL be synthesized.

Verification
REQ-022 Reset, then write the FIPS-197 AES-256 schedule (key 000102..1f): after the 15th write, outKeyReady = 1; outKeyErr = 0.
REQ-023 Encrypt start: cycle +1 gives idx 0 with key 000102030405060708090a0b0c0d0e0f; cycle +2 gives idx 1 with key 101112131415161718191a1b1c1d1e1f; cycle +15 gives idx 14 with outLastRound = 1; cycle +16 gives outBusy = 1 and outRoundValid = 0; cycle +17 gives outBusy = 0.
REQ-024 Decrypt start: cycle +1 gives idx 14 with key 24fc79ccbf0979e9371ac23c6d68de36; cycle +15 gives idx 0 with key 000102..0f and outLastRound = 1.
REQ-025 inStart with outKeyReady = 0: no outRoundValid and outBusy stays 0. A key write at wp = 0 clears outKeyReady.
REQ-026 inKeyWr during RUN: outKeyErr = 1, the sequence still emits the original keys, and wp is unchanged.
REQ-027 inRst pulsed at RUN cycle 5: all outputs go to reset values asynchronously, and outKeyReady = 0. With AES_RKR_INV_MIX_EN defined, a decrypt run outputs InvMixColumns(key) at idx 1..13, and idx 0 and 14 are raw.
